// File: rtl/ibex_scramble_key_arbiter_if.sv
// ---------------------------------------------------------------------------
// ibex_scramble_key_arbiter_if
//
// Purpose:
//   Groups the single OTP scramble-key handshake into one bundle. The key
//   arbiter is the requesting side (master). The OTP / key-manager model is
//   the answering side (slave).
//
// Signals:
//   scramble_req        master -> slave  request a fresh key/nonce
//   scramble_key_valid  slave  -> master response valid, single cycle
//   scramble_key        slave  -> master key, KeyW bits
//   scramble_nonce      slave  -> master nonce, NonceW bits
// ---------------------------------------------------------------------------
interface ibex_scramble_key_arbiter_if #(
    parameter int unsigned KeyW   = 128,
    parameter int unsigned NonceW = 64
);

    logic              scramble_req;
    logic              scramble_key_valid;
    logic [KeyW-1:0]   scramble_key;
    logic [NonceW-1:0] scramble_nonce;

    // The arbiter drives the request and consumes the response.
    modport master (
        output scramble_req,
        input  scramble_key_valid,
        input  scramble_key,
        input  scramble_nonce
    );

    // The OTP side sees the request and produces the response.
    modport slave (
        input  scramble_req,
        output scramble_key_valid,
        output scramble_key,
        output scramble_nonce
    );

endinterface

// File: rtl/ibex_scramble_key_arbiter.sv
// ---------------------------------------------------------------------------
// ibex_scramble_key_arbiter
//
// Purpose:
//   Shares one OTP scramble-key port among NumChannels key consumers, such as
//   the icache tag/data RAMs and future scrambled memories. Each channel has
//   its own key, nonce and key-valid flag. When a channel is invalidated it
//   becomes pending. Pending channels are served one at a time in round-robin
//   order.
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   invalidate_i     per-channel one-cycle re-key request
//   key_valid_o      per-channel "key usable" flag
//   key_o            per-channel key, channel c at [c*KeyW +: KeyW]
//   nonce_o          per-channel nonce, channel c at [c*NonceW +: NonceW]
//   otp              OTP handshake (ibex_scramble_key_arbiter_if.master)
//   busy_o           any channel pending or a request in flight
//   timeout_alert_o  one-cycle pulse when an OTP request times out
//
// Configuration:
//   IBEX_SCR_KEY_TIMEOUT_EN  When this macro is defined, a request that has
//                            been in flight for TimeoutCycles cycles is
//                            abandoned. The channel stays pending and
//                            timeout_alert_o pulses. When the macro is
//                            undefined, a request waits indefinitely and
//                            timeout_alert_o is tied low.
// ---------------------------------------------------------------------------
module ibex_scramble_key_arbiter #(
    parameter int unsigned       NumChannels   = 2,
    parameter int unsigned       KeyW          = 128,
    parameter int unsigned       NonceW        = 64,
    parameter int unsigned       TimeoutCycles = 1024,
    parameter logic [KeyW-1:0]   RndCnstKey    = 128'h14e8cecae3040d5e12286bb3cc113298,
    parameter logic [NonceW-1:0] RndCnstNonce  = 64'hf79780bc735f3843
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumChannels-1:0]          invalidate_i,
    output logic [NumChannels-1:0]          key_valid_o,
    output logic [NumChannels*KeyW-1:0]     key_o,
    output logic [NumChannels*NonceW-1:0]   nonce_o,
    ibex_scramble_key_arbiter_if.master     otp,
    output logic                            busy_o,
    output logic                            timeout_alert_o
);

    localparam int unsigned IdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StReq  = 1'b1
    } state_e;

    state_e                               state_q, state_d;
    logic [IdxW-1:0]                      active_q, active_d;
    logic [IdxW-1:0]                      rrPtr_q, rrPtr_d;
    logic [NumChannels-1:0]               pending_q, pending_d;
    logic [NumChannels-1:0]               keyValid_q, keyValid_d;
    logic [NumChannels-1:0][KeyW-1:0]     key_q, key_d;
    logic [NumChannels-1:0][NonceW-1:0]   nonce_q, nonce_d;

    logic                                 grantFound;
    logic [IdxW-1:0]                      grantIdx;
    logic                                 capture;
    logic                                 timeoutFire;

    // Returns the channel index that is "offset" positions after "base",
    // wrapping modulo NumChannels. This keeps round-robin correct when the
    // channel count is not a power of two.
    function automatic logic [IdxW-1:0] wrapIdx(input logic [IdxW-1:0] base,
                                                input int unsigned     offset);
        int unsigned sum;
        sum = (32'(base) + offset) % NumChannels;
        return sum[IdxW-1:0];
    endfunction

    // A response is only meaningful while a request is outstanding. In IDLE,
    // scramble_key_valid is ignored and no register changes.
    assign capture = (state_q == StReq) && otp.scramble_key_valid;

    // Round-robin search. The scan starts one position after the channel that
    // was granted last and walks a full lap. The first pending channel found
    // wins. A channel therefore never waits more than NumChannels grants.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = rrPtr_q;
        for (int unsigned i = 1; i <= NumChannels; i++) begin
            if (!grantFound && pending_q[wrapIdx(rrPtr_q, i)]) begin
                grantFound = 1'b1;
                grantIdx   = wrapIdx(rrPtr_q, i);
            end
        end
    end

`ifdef IBEX_SCR_KEY_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] timeoutCnt_q, timeoutCnt_d;

    // The timeout fires in the cycle where the counter has reached
    // TimeoutCycles and no response has arrived. If a response arrives in
    // that same cycle, the capture wins and the timeout is suppressed.
    assign timeoutFire = (state_q == StReq) && !otp.scramble_key_valid &&
                         (timeoutCnt_q == CntW'(TimeoutCycles));

    // The counter is held at zero while idle, so every request starts
    // counting from zero. It advances once per cycle spent in REQ.
    always_comb begin
        timeoutCnt_d = timeoutCnt_q;
        if (state_q == StIdle) begin
            timeoutCnt_d = '0;
        end else if (!timeoutFire) begin
            timeoutCnt_d = timeoutCnt_q + CntW'(1);
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeoutCnt_q <= '0;
        end else begin
            timeoutCnt_q <= timeoutCnt_d;
        end
    end
`else
    logic unused_timeoutCycles;

    // Without the timeout feature, a request waits for the OTP indefinitely.
    assign timeoutFire          = 1'b0;
    assign unused_timeoutCycles = ^TimeoutCycles;
`endif

    // FSM next state. IDLE grants the next pending channel. REQ holds until
    // the OTP answers or, when the timeout feature is built, until the
    // timeout fires. A timeout leaves the channel pending, so the channel is
    // simply re-arbitrated behind any other waiting channels.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        rrPtr_d  = rrPtr_q;
        unique case (state_q)
            StIdle: begin
                if (grantFound) begin
                    active_d = grantIdx;
                    rrPtr_d  = grantIdx;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (capture || timeoutFire) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Per-channel bookkeeping. Invalidates are latched for every channel in
    // the same cycle. When an invalidate for the active channel coincides
    // with a capture, the new key is still stored, but the channel stays
    // invalid and pending. The key it received may already be stale from the
    // consumer's point of view, so it must be re-requested.
    always_comb begin
        pending_d  = pending_q | invalidate_i;
        keyValid_d = keyValid_q & ~invalidate_i;
        key_d      = key_q;
        nonce_d    = nonce_q;
        if (capture) begin
            key_d[active_q]   = otp.scramble_key;
            nonce_d[active_q] = otp.scramble_nonce;
            if (!invalidate_i[active_q]) begin
                pending_d[active_q]  = 1'b0;
                keyValid_d[active_q] = 1'b1;
            end
        end
    end

    // State and data registers. Reset puts every channel back on the default
    // key/nonce with valid set. Reset also drops any in-flight request
    // immediately, because scramble_req is a decode of state_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            active_q   <= '0;
            rrPtr_q    <= IdxW'(NumChannels - 1);
            pending_q  <= '0;
            keyValid_q <= '1;
            key_q      <= {NumChannels{RndCnstKey}};
            nonce_q    <= {NumChannels{RndCnstNonce}};
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            rrPtr_q    <= rrPtr_d;
            pending_q  <= pending_d;
            keyValid_q <= keyValid_d;
            key_q      <= key_d;
            nonce_q    <= nonce_d;
        end
    end

    // Every output except the timeout pulse is decoded purely from
    // registers, so the request line to OTP is glitch-free.
    assign otp.scramble_req = (state_q == StReq);
    assign busy_o           = (|pending_q) | (state_q == StReq);
    assign key_valid_o      = keyValid_q;
    assign key_o            = key_q;
    assign nonce_o          = nonce_q;
    assign timeout_alert_o  = timeoutFire;

endmodule

// File: tb/tb_ibex_scramble_key_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ibex_scramble_key_arbiter
//
// Purpose:
//   Self-checking bench for ibex_scramble_key_arbiter with two channels and a
//   16-cycle timeout. A vector table drives the single-channel, dual-channel,
//   collision and round-robin sequences. Hand-written sequences cover the
//   reset state, the timeout behaviour and a reset taken in the middle of a
//   request.
//
// Configuration:
//   IBEX_SCR_KEY_TIMEOUT_EN  selects which timeout expectations are checked
// ---------------------------------------------------------------------------
module tb_ibex_scramble_key_arbiter;

    localparam int unsigned NumCh   = 2;
    localparam int unsigned KeyW    = 128;
    localparam int unsigned NonceW  = 64;
    localparam int unsigned Timeout = 16;
    localparam int unsigned NumVecs = 33;

    localparam logic [KeyW-1:0]   DefKey    = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [NonceW-1:0] DefNonce  = 64'h5555_aaaa_3333_cccc;
    localparam logic [KeyW-1:0]   JunkKey   = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
    localparam logic [NonceW-1:0] JunkNonce = 64'hbad0_bad0_bad0_bad0;
    localparam logic [KeyW-1:0]   KeyA5     = {16{8'hA5}};
    localparam logic [NonceW-1:0] NonceA5   = {8{8'h5A}};

    typedef struct {
        logic              resetBefore;
        logic [1:0]        inv;
        logic              otpValid;
        logic [KeyW-1:0]   otpKey;
        logic [NonceW-1:0] otpNonce;
        logic [1:0]        expKv;
        logic              expReq;
        logic              expBusy;
        logic [KeyW-1:0]   expKey0;
        logic [KeyW-1:0]   expKey1;
        logic [NonceW-1:0] expNonce0;
        logic [NonceW-1:0] expNonce1;
    } vec_t;

    logic                     clk;
    logic                     rstN;
    logic [NumCh-1:0]         invalidate;
    logic [NumCh-1:0]         keyValid;
    logic [NumCh*KeyW-1:0]    keyFlat;
    logic [NumCh*NonceW-1:0]  nonceFlat;
    logic                     busy;
    logic                     timeoutAlert;

    int total = 0;
    int bad   = 0;

    vec_t vecs [NumVecs];

    ibex_scramble_key_arbiter_if #(.KeyW(KeyW), .NonceW(NonceW)) otpIf ();

    ibex_scramble_key_arbiter #(
        .NumChannels  (NumCh),
        .KeyW         (KeyW),
        .NonceW       (NonceW),
        .TimeoutCycles(Timeout),
        .RndCnstKey   (DefKey),
        .RndCnstNonce (DefNonce)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .invalidate_i   (invalidate),
        .key_valid_o    (keyValid),
        .key_o          (keyFlat),
        .nonce_o        (nonceFlat),
        .otp            (otpIf.master),
        .busy_o         (busy),
        .timeout_alert_o(timeoutAlert)
    );

    // Free-running 10 time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct, recognisable OTP key/nonce values per transaction.
    function automatic logic [KeyW-1:0] otpKeyOf(input int i);
        return {4{32'h1111_1111 * i}};
    endfunction

    function automatic logic [NonceW-1:0] otpNonceOf(input int i);
        return {2{32'h0f0f_0000 + i}};
    endfunction

    function automatic vec_t mk(input logic rb, input logic [1:0] inv, input logic v,
                                input logic [KeyW-1:0] k, input logic [NonceW-1:0] n,
                                input logic [1:0] ekv, input logic er, input logic eb,
                                input logic [KeyW-1:0] ek0, input logic [KeyW-1:0] ek1,
                                input logic [NonceW-1:0] en0, input logic [NonceW-1:0] en1);
        vec_t r;
        r.resetBefore = rb;  r.inv = inv;  r.otpValid = v;  r.otpKey = k;  r.otpNonce = n;
        r.expKv = ekv;  r.expReq = er;  r.expBusy = eb;
        r.expKey0 = ek0;  r.expKey1 = ek1;  r.expNonce0 = en0;  r.expNonce1 = en1;
        return r;
    endfunction

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic checkField(input string name, input logic [KeyW-1:0] act,
                              input logic [KeyW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        invalidate                = '0;
        otpIf.scramble_key_valid  = 1'b0;
        otpIf.scramble_key        = JunkKey;
        otpIf.scramble_nonce      = JunkNonce;
    endtask

    // Reset for two cycles, release it away from the active edge, and
    // return one delay step after the next rising edge.
    task automatic doReset();
        driveIdle();
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        checkField({tag, ".keyValid"}, KeyW'(keyValid), KeyW'(v.expKv));
        checkField({tag, ".req"}, KeyW'(otpIf.scramble_req), KeyW'(v.expReq));
        checkField({tag, ".busy"}, KeyW'(busy), KeyW'(v.expBusy));
        checkField({tag, ".alert"}, KeyW'(timeoutAlert), '0);
        checkField({tag, ".key0"}, keyFlat[0 +: KeyW], v.expKey0);
        checkField({tag, ".key1"}, keyFlat[KeyW +: KeyW], v.expKey1);
        checkField({tag, ".nonce0"}, KeyW'(nonceFlat[0 +: NonceW]), KeyW'(v.expNonce0));
        checkField({tag, ".nonce1"}, KeyW'(nonceFlat[NonceW +: NonceW]), KeyW'(v.expNonce1));
    endtask

    // Drive one vector just after an edge, clock it in, and sample one
    // delay step after the following edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        if (v.resetBefore) doReset();
        invalidate               = v.inv;
        otpIf.scramble_key_valid = v.otpValid;
        otpIf.scramble_key       = v.otpKey;
        otpIf.scramble_nonce     = v.otpNonce;
        @(posedge clk);
        #1;
        driveIdle();
        checkOutput(v, $sformatf("vec%0d", idx));
    endtask

    initial begin
        logic [KeyW-1:0] k1, k2, k3, k4, k5, k6, k7, k8, k9, kt;
        logic [NonceW-1:0] n1, n2, n3, n4, n5, n6, n7, n8, n9, nt;
        logic expAlert;
        k1 = otpKeyOf(1); k2 = otpKeyOf(2); k3 = otpKeyOf(3); k4 = otpKeyOf(4); k5 = otpKeyOf(5);
        k6 = otpKeyOf(6); k7 = otpKeyOf(7); k8 = otpKeyOf(8); k9 = otpKeyOf(9); kt = otpKeyOf(10);
        n1 = otpNonceOf(1); n2 = otpNonceOf(2); n3 = otpNonceOf(3); n4 = otpNonceOf(4); n5 = otpNonceOf(5);
        n6 = otpNonceOf(6); n7 = otpNonceOf(7); n8 = otpNonceOf(8); n9 = otpNonceOf(9); nt = otpNonceOf(10);

        // Channel 0 re-key: invalidate, then request for three cycles, then the A5 key.
        vecs[0]  = mk(0, 2'b01, 0, JunkKey, JunkNonce, 2'b10, 0, 1, DefKey, DefKey, DefNonce, DefNonce);
        vecs[1]  = mk(0, 2'b00, 0, JunkKey, JunkNonce, 2'b10, 1, 1, DefKey, DefKey, DefNonce, DefNonce);
        vecs[2]  = vecs[1];
        vecs[3]  = vecs[1];
        vecs[4]  = mk(0, 2'b00, 1, KeyA5, NonceA5, 2'b11, 0, 0, KeyA5, DefKey, NonceA5, DefNonce);
        // Both channels invalidated together from reset; OTP answers on the fourth request cycle.
        vecs[5]  = mk(1, 2'b11, 0, JunkKey, JunkNonce, 2'b00, 0, 1, DefKey, DefKey, DefNonce, DefNonce);
        vecs[6]  = mk(0, 2'b00, 0, JunkKey, JunkNonce, 2'b00, 1, 1, DefKey, DefKey, DefNonce, DefNonce);
        vecs[7]  = vecs[6];
        vecs[8]  = vecs[6];
        vecs[9]  = vecs[6];
        vecs[10] = mk(0, 2'b00, 1, k1, n1, 2'b01, 0, 1, k1, DefKey, n1, DefNonce);
        vecs[11] = mk(0, 2'b00, 0, JunkKey, JunkNonce, 2'b01, 1, 1, k1, DefKey, n1, DefNonce);
        vecs[12] = vecs[11];
        vecs[13] = vecs[11];
        vecs[14] = vecs[11];
        vecs[15] = mk(0, 2'b00, 1, k2, n2, 2'b11, 0, 0, k1, k2, n1, n2);
        // Invalidate of channel 1 colliding with its own capture.
        vecs[16] = mk(0, 2'b10, 0, JunkKey, JunkNonce, 2'b01, 0, 1, k1, k2, n1, n2);
        vecs[17] = mk(0, 2'b00, 0, JunkKey, JunkNonce, 2'b01, 1, 1, k1, k2, n1, n2);
        vecs[18] = mk(0, 2'b10, 1, k3, n3, 2'b01, 0, 1, k1, k3, n1, n3);
        vecs[19] = mk(0, 2'b00, 0, JunkKey, JunkNonce, 2'b01, 1, 1, k1, k3, n1, n3);
        vecs[20] = mk(0, 2'b00, 1, k4, n4, 2'b11, 0, 0, k1, k4, n1, n4);
        // Response while idle is ignored.
        vecs[21] = mk(0, 2'b00, 1, k5, n5, 2'b11, 0, 0, k1, k4, n1, n4);
        // Round robin after channel 1 was last served: channel 0 goes first.
        vecs[22] = mk(0, 2'b11, 0, JunkKey, JunkNonce, 2'b00, 0, 1, k1, k4, n1, n4);
        vecs[23] = mk(0, 2'b00, 0, JunkKey, JunkNonce, 2'b00, 1, 1, k1, k4, n1, n4);
        vecs[24] = mk(0, 2'b00, 1, k6, n6, 2'b01, 0, 1, k6, k4, n6, n4);
        vecs[25] = mk(0, 2'b00, 0, JunkKey, JunkNonce, 2'b01, 1, 1, k6, k4, n6, n4);
        vecs[26] = mk(0, 2'b00, 1, k7, n7, 2'b11, 0, 0, k6, k7, n6, n7);
        // Invalidate of the non-active channel while a request is in flight.
        vecs[27] = mk(0, 2'b01, 0, JunkKey, JunkNonce, 2'b10, 0, 1, k6, k7, n6, n7);
        vecs[28] = mk(0, 2'b00, 0, JunkKey, JunkNonce, 2'b10, 1, 1, k6, k7, n6, n7);
        vecs[29] = mk(0, 2'b10, 0, JunkKey, JunkNonce, 2'b00, 1, 1, k6, k7, n6, n7);
        vecs[30] = mk(0, 2'b00, 1, k8, n8, 2'b01, 0, 1, k8, k7, n8, n7);
        vecs[31] = mk(0, 2'b00, 0, JunkKey, JunkNonce, 2'b01, 1, 1, k8, k7, n8, n7);
        vecs[32] = mk(0, 2'b00, 1, k9, n9, 2'b11, 0, 0, k8, k9, n8, n9);

        // Reset state.
        rstN = 1'b0;
        doReset();
        checkOutput(mk(0, 2'b00, 0, JunkKey, JunkNonce, 2'b11, 0, 0, DefKey, DefKey, DefNonce, DefNonce), "reset");

        for (int i = 0; i < int'(NumVecs); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Timeout sequence on channel 0 with the OTP silent.
        invalidate = 2'b01;
        @(posedge clk); #1;
        driveIdle();
        @(posedge clk); #1;
        checkField("to.reqRise", KeyW'(otpIf.scramble_req), KeyW'(1'b1));
        for (int k = 1; k <= int'(Timeout); k++) begin
            @(posedge clk); #1;
`ifdef IBEX_SCR_KEY_TIMEOUT_EN
            expAlert = (k == int'(Timeout));
`else
            expAlert = 1'b0;
`endif
            checkField($sformatf("to.alert%0d", k), KeyW'(timeoutAlert), KeyW'(expAlert));
            checkField($sformatf("to.req%0d", k), KeyW'(otpIf.scramble_req), KeyW'(1'b1));
        end
        @(posedge clk); #1;
`ifdef IBEX_SCR_KEY_TIMEOUT_EN
        checkField("to.reqDrop", KeyW'(otpIf.scramble_req), KeyW'(1'b0));
`else
        checkField("to.reqHeld", KeyW'(otpIf.scramble_req), KeyW'(1'b1));
`endif
        checkField("to.alertAfter", KeyW'(timeoutAlert), KeyW'(1'b0));
        checkField("to.kvKept", KeyW'(keyValid), KeyW'(2'b10));
        checkField("to.busyKept", KeyW'(busy), KeyW'(1'b1));
        @(posedge clk); #1;
        checkField("to.reqAgain", KeyW'(otpIf.scramble_req), KeyW'(1'b1));
        otpIf.scramble_key_valid = 1'b1;
        otpIf.scramble_key       = kt;
        otpIf.scramble_nonce     = nt;
        @(posedge clk); #1;
        driveIdle();
        checkOutput(mk(0, 2'b00, 0, JunkKey, JunkNonce, 2'b11, 0, 0, kt, k9, nt, n9), "to.done");

        // Reset taken in the middle of a request on channel 1.
        invalidate = 2'b10;
        @(posedge clk); #1;
        driveIdle();
        @(posedge clk); #1;
        checkField("rst.reqBefore", KeyW'(otpIf.scramble_req), KeyW'(1'b1));
        #2;
        rstN = 1'b0;
        #1;
        checkField("rst.reqAsync", KeyW'(otpIf.scramble_req), KeyW'(1'b0));
        checkField("rst.kvAsync", KeyW'(keyValid), KeyW'(2'b11));
        checkField("rst.key0Async", keyFlat[0 +: KeyW], DefKey);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;
        checkOutput(mk(0, 2'b00, 0, JunkKey, JunkNonce, 2'b11, 0, 0, DefKey, DefKey, DefNonce, DefNonce), "rst.after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
